// File: rtl/gpr_write_arbiter.sv
// Shares the GPR write port between the writeback stage and a FIFO of late mul/div results.
// Optional WB_ARB_BYPASS_EN: an empty FIFO on an idle port forwards a mul/div result directly.
module gpr_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        gpr_we,
    output logic [4:0]  gpr_addr,
    output logic [31:0] gpr_data,
    output logic        stall_req,
    output logic [3:0]  md_count
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]       count;
    logic [3:0]       starve_cnt;

    logic wb_eff;
    logic fifo_empty;
    logic accept;
    logic drain;
    logic bypass;
    logic push;

    assign md_ready  = (count != DEPTH_C);
    assign stall_req = (starve_cnt >= LIMIT_C);
    assign md_count  = count;

    always_comb begin
        wb_eff     = wb_we && (wb_addr != 5'd0);
        fifo_empty = (count == 4'd0);
        // A handshake to $0 completes but carries nothing worth storing.
        accept     = md_valid && md_ready && (md_addr != 5'd0);
        drain      = !fifo_empty && (stall_req || !wb_eff);
`ifdef WB_ARB_BYPASS_EN
        bypass     = accept && fifo_empty && !stall_req && !wb_eff;
`else
        bypass     = 1'b0;
`endif
        push       = accept && !bypass;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= md_addr;
            fifo_data[wr_ptr] <= md_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpr_we     <= 1'b0;
            gpr_addr   <= 5'd0;
            gpr_data   <= 32'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= 4'd0;
            starve_cnt <= 4'd0;
        end else begin
            if (drain) begin
                gpr_we   <= 1'b1;
                gpr_addr <= fifo_addr[rd_ptr];
                gpr_data <= fifo_data[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (wb_eff && !stall_req) begin
                gpr_we   <= 1'b1;
                gpr_addr <= wb_addr;
                gpr_data <= wb_data;
            end else if (bypass) begin
                gpr_we   <= 1'b1;
                gpr_addr <= md_addr;
                gpr_data <= md_data;
            end else begin
                gpr_we   <= 1'b0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({push, drain})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase

            // Counts cycles the head sits blocked; saturates so stall_req holds until the drain.
            if (fifo_empty || drain) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt < LIMIT_C) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed bench for gpr_write_arbiter (DEPTH=2, STARVE_LIMIT=4), honouring WB_ARB_BYPASS_EN if defined.
module tb_gpr_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        gpr_we;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_data;
    logic        stall_req;
    logic [3:0]  md_count;

    int n_cmp = 0;
    int n_err = 0;

    gpr_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .gpr_we    (gpr_we),
        .gpr_addr  (gpr_addr),
        .gpr_data  (gpr_data),
        .stall_req (stall_req),
        .md_count  (md_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] mdat);
        wb_we    = we;
        wb_addr  = wa;
        wb_data  = wd;
        md_valid = mv;
        md_addr  = ma;
        md_data  = mdat;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        idle();
        idle();
        reset = 1'b0;
        chk("rst_gpr_we",   32'(gpr_we),    32'd0);
        chk("rst_gpr_addr", 32'(gpr_addr),  32'd0);
        chk("rst_gpr_data", gpr_data,       32'd0);
        chk("rst_count",    32'(md_count),  32'd0);
        chk("rst_ready",    32'(md_ready),  32'd1);
        chk("rst_stall",    32'(stall_req), 32'd0);

        // Pipeline write: one cycle latency
        cyc(1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        chk("wb_we",    32'(gpr_we),   32'd1);
        chk("wb_addr",  32'(gpr_addr), 32'd8);
        chk("wb_data",  gpr_data,      32'h0000_1234);
        chk("wb_count", 32'(md_count), 32'd0);

        // Single mul/div result on an idle pipeline
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
`ifdef WB_ARB_BYPASS_EN
        chk("md1_we",    32'(gpr_we),   32'd1);
        chk("md1_addr",  32'(gpr_addr), 32'd9);
        chk("md1_data",  gpr_data,      32'hDEAD_BEEF);
        chk("md1_count", 32'(md_count), 32'd0);
        idle();
        chk("md1_after", 32'(gpr_we),   32'd0);
`else
        chk("md1_we_e1",    32'(gpr_we),   32'd0);
        chk("md1_count_e1", 32'(md_count), 32'd1);
        idle();
        chk("md1_we",    32'(gpr_we),   32'd1);
        chk("md1_addr",  32'(gpr_addr), 32'd9);
        chk("md1_data",  gpr_data,      32'hDEAD_BEEF);
        chk("md1_count", 32'(md_count), 32'd0);
`endif

        // Three results while the pipeline writes every cycle
        do_reset();
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd3, 32'h33);
        chk("bp_count1", 32'(md_count), 32'd1);
        chk("bp_wb1",    32'(gpr_addr), 32'd10);
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd4, 32'h44);
        chk("bp_count2", 32'(md_count), 32'd2);
        chk("bp_ready0", 32'(md_ready), 32'd0);
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd5, 32'h55);
        chk("bp_hold",   32'(md_count), 32'd2);
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd5, 32'h55);
        chk("bp_nostall3", 32'(stall_req), 32'd0);
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd5, 32'h55);
        chk("bp_stall4",   32'(stall_req), 32'd1);
        chk("bp_wb_still", 32'(gpr_addr),  32'd10);
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd5, 32'h55);
        chk("bp_drain3_addr", 32'(gpr_addr),  32'd3);
        chk("bp_drain3_data", gpr_data,       32'h33);
        chk("bp_stall_drop",  32'(stall_req), 32'd0);
        chk("bp_count_pop",   32'(md_count),  32'd1);
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b1, 5'd5, 32'h55);
        chk("bp_push5",   32'(md_count), 32'd2);
        chk("bp_wb_back", 32'(gpr_addr), 32'd10);
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b0, 5'd0, 32'd0);
        chk("bp_stall_again", 32'(stall_req), 32'd1);
        cyc(1'b1, 5'd10, 32'hAAAA_0000, 1'b0, 5'd0, 32'd0);
        chk("bp_drain4_addr", 32'(gpr_addr), 32'd4);
        chk("bp_drain4_data", gpr_data,      32'h44);
        idle();
        chk("bp_drain5_addr", 32'(gpr_addr), 32'd5);
        chk("bp_drain5_data", gpr_data,      32'h55);
        chk("bp_empty",       32'(md_count), 32'd0);

        // Writes to $0 are dropped from both sources
        idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1111);
        chk("r0_md_we",    32'(gpr_we),   32'd0);
        chk("r0_md_count", 32'(md_count), 32'd0);
        cyc(1'b1, 5'd0, 32'h2222, 1'b0, 5'd0, 32'd0);
        chk("r0_wb_we", 32'(gpr_we), 32'd0);
        idle();
        chk("r0_after", 32'(gpr_we), 32'd0);

        // Reset with two buffered entries
        cyc(1'b1, 5'd7, 32'h7, 1'b1, 5'd11, 32'hB);
        cyc(1'b1, 5'd7, 32'h7, 1'b1, 5'd12, 32'hC);
        chk("mr_full", 32'(md_count), 32'd2);
        do_reset();
        chk("mr_count", 32'(md_count),  32'd0);
        chk("mr_ready", 32'(md_ready),  32'd1);
        chk("mr_stall", 32'(stall_req), 32'd0);
        chk("mr_we",    32'(gpr_we),    32'd0);
        idle();
        chk("mr_no_stale1", 32'(gpr_we), 32'd0);
        idle();
        chk("mr_no_stale2", 32'(gpr_we), 32'd0);

        // One entry buffered, push and pop in the same cycle
        cyc(1'b1, 5'd7, 32'h7, 1'b1, 5'd13, 32'hD0D0);
        chk("pp_count1", 32'(md_count), 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hE0E0);
        chk("pp_head_addr", 32'(gpr_addr), 32'd13);
        chk("pp_head_data", gpr_data,      32'hD0D0);
        chk("pp_count",     32'(md_count), 32'd1);
        idle();
        chk("pp_next_we",   32'(gpr_we),   32'd1);
        chk("pp_next_addr", 32'(gpr_addr), 32'd14);
        chk("pp_next_data", gpr_data,      32'hE0E0);
        chk("pp_empty",     32'(md_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
